layer_2_maxpool: RTL

Streaming 2x2, stride-2 max-pooling stage for one FP32 feature map, placed directly downstream of a layer-2 feature-map convolution block. It consumes the per-pixel raster stream that block produces, with one pixel per `valid_in`. It emits one pooled pixel per 2x2 window, turning an IMG_SIZE x IMG_SIZE map into IMG_SIZE/2 x IMG_SIZE/2. One half-row line buffer holds the pairwise maxima of each even row until the matching odd row arrives.

---
 rtl/yolo_pkg.sv | 32 +++
 rtl/fp32_max2.sv | 18 +
 rtl/layer_2_maxpool.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/yolo_pkg.sv
// -----------------------------------------------------------------------------
// yolo_pkg
// Shared definitions for the YOLO feature-map pipeline stages.
//   fp32_t            : raw IEEE-754 single-precision pixel word
//   IMG_SIZE_DEFAULT  : default feature-map width/height for layer 2
//   fp_max(a, b)      : sign-magnitude maximum of two raw FP32 words
// -----------------------------------------------------------------------------
package yolo_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int IMG_SIZE_DEFAULT = 208;

  typedef logic [DATA_WIDTH-1:0] fp32_t;

  // Compares raw bit patterns as sign-magnitude numbers. NaN and Inf get no
  // special treatment. When the signs differ, the operand with sign 0 wins,
  // so +0 beats -0. When the values are bit-identical, a is returned.
  function automatic fp32_t fp_max(input fp32_t a, input fp32_t b);
    fp32_t y;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      y = a[DATA_WIDTH-1] ? b : a;
    end else if (a[DATA_WIDTH-1] == 1'b0) begin
      // both positive: larger magnitude is larger value
      y = (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
    end else begin
      // both negative: smaller magnitude is larger value
      y = (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) ? b : a;
    end
    return y;
  endfunction

endpackage

// File: rtl/fp32_max2.sv
// -----------------------------------------------------------------------------
// fp32_max2
// Purely combinational two-input FP32 maximum (see yolo_pkg::fp_max).
// Ports:
//   a, b : raw FP32 operands
//   y    : the larger of a and b; a when the two are bit-identical
// -----------------------------------------------------------------------------
module fp32_max2
  import yolo_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y
);

  assign y = fp_max(a, b);

endmodule

// File: rtl/layer_2_maxpool.sv
// -----------------------------------------------------------------------------
// layer_2_maxpool
// Streaming 2x2, stride-2 max-pool over a raster-order FP32 feature map.
// An IMG_SIZE x IMG_SIZE input becomes an IMG_SIZE/2 x IMG_SIZE/2 output.
// A half-row line buffer holds the pairwise maxima of each even row until
// the matching odd row arrives.
//
// Parameters:
//   DATA_WIDTH : pixel width (FP32, 32)
//   IMG_SIZE   : input map width and height; must be even
// Ports:
//   Clk        : clock
//   Rst        : asynchronous active-high reset
//   data_in    : input pixel, row-major raster order
//   valid_in   : data_in valid this cycle; idle cycles change no state
//   data_out   : pooled pixel; holds its last value between pulses
//   valid_out  : one-cycle qualifier for data_out
//   frame_done : (only with MAXPOOL_FRAME_DONE_EN defined) pulses together
//                with the valid_out of the last pooled pixel of a frame
//
// Build option: define MAXPOOL_FRAME_DONE_EN to add the frame_done port.
// -----------------------------------------------------------------------------
module layer_2_maxpool
  import yolo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = IMG_SIZE_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
`ifdef MAXPOOL_FRAME_DONE_EN
  ,
  output logic                  frame_done
`endif
);

  localparam int CW    = $clog2(IMG_SIZE);
  localparam int HALF  = IMG_SIZE / 2;
  localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG_SIZE - 1);

  // Row/column position of the pixel currently on data_in
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;

  // Horizontal holding register. On even rows it holds the left pixel of a
  // pair. On odd rows it holds the running maximum of the window.
  fp32_t hreg_q, hreg_d;

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;

  // Half-row line buffer of even-row pair maxima (not reset; always written
  // before it is read)
  fp32_t lbuf_q [HALF];

  logic [AW-1:0] lb_addr_s;
  logic          lb_we_s;
  fp32_t         lb_rd_s;
  fp32_t         max_even_s;
  fp32_t         odd_a_s;
  fp32_t         max_odd_s;
  logic          col_last_s;
  logic          row_last_s;

  assign col_last_s = (col_q == LAST_IDX);
  assign row_last_s = (row_q == LAST_IDX);
  assign lb_addr_s  = AW'(col_q >> 1);
  assign lb_rd_s    = lbuf_q[lb_addr_s];

  // Even-row write path: maximum of the horizontal pair headed for lbuf
  fp32_max2 u_max_even (
    .a (hreg_q),
    .b (data_in),
    .y (max_even_s)
  );

  // Odd-row path, time-shared by column parity. An even column merges the
  // stored upper pair with the new pixel. An odd column merges the running
  // window maximum with the bottom-right pixel.
  assign odd_a_s = col_q[0] ? hreg_q : lb_rd_s;

  fp32_max2 u_max_odd (
    .a (odd_a_s),
    .b (data_in),
    .y (max_odd_s)
  );

`ifdef MAXPOOL_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;
`endif

  // Next-state logic for counters, holding register and output
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hreg_d      = hreg_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    lb_we_s     = 1'b0;
`ifdef MAXPOOL_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif
    if (valid_in) begin
      if (col_last_s) begin
        col_d = {CW{1'b0}};
        row_d = row_last_s ? {CW{1'b0}} : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end

      case ({row_q[0], col_q[0]})
        2'b00: hreg_d = data_in;
        2'b01: lb_we_s = 1'b1;
        2'b10: hreg_d = max_odd_s;
        2'b11: begin
          data_out_d  = max_odd_s;
          valid_out_d = 1'b1;
`ifdef MAXPOOL_FRAME_DONE_EN
          frame_done_d = col_last_s & row_last_s;
`endif
        end
        default: hreg_d = hreg_q;
      endcase
    end else begin
      col_d = col_q;
    end
  end

  // State and output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col_q       <= {CW{1'b0}};
      row_q       <= {CW{1'b0}};
      hreg_q      <= {DATA_WIDTH{1'b0}};
      data_out_q  <= {DATA_WIDTH{1'b0}};
      valid_out_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hreg_q      <= hreg_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Line buffer write port
  always_ff @(posedge Clk) begin
    if (lb_we_s) begin
      lbuf_q[lb_addr_s] <= max_even_s;
    end
  end

`ifdef MAXPOOL_FRAME_DONE_EN
  // End-of-frame pulse register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`endif

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule
